// File: rtl/rr_arb_requester_if.sv
// Command/arbiter/bus bundle for one rr_arb_requester; master = requester, slave = its environment.
interface rr_arb_requester_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  logic [LEN_W-1:0]  cmd_len;
  logic              req;
  logic              gnt;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              bus_last;
  logic              busy;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    input  cmd_valid, cmd_data, cmd_len, gnt,
    output cmd_ready, req, bus_valid, bus_data, bus_last, busy, fifo_count
  );

  modport slave (
    output cmd_valid, cmd_data, cmd_len, gnt,
    input  cmd_ready, req, bus_valid, bus_data, bus_last, busy, fifo_count
  );
endinterface

// File: rtl/rr_arb_requester.sv
// Requester agent for a round-robin req/gnt arbiter: command FIFO plus burst FSM.
// Optional RR_REQ_BACK_TO_BACK_EN: chain queued bursts without dropping req.
module rr_arb_requester #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  rr_arb_requester_if.master  rq_if
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [LEN_W-1:0]  len_mem  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] cur_data_q, cur_data_d;
  logic [LEN_W-1:0]  cur_len_q, cur_len_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic full_c, empty_c, push_c, pop_c, beat_c, last_c;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign push_c  = rq_if.cmd_valid & ~full_c;
  assign beat_c  = req_q & rq_if.gnt;
  assign last_c  = beat_c & (beat_cnt_q == cur_len_q);

  // FIFO storage; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (push_c) begin
      data_mem[wr_ptr_q] <= rq_if.cmd_data;
      len_mem[wr_ptr_q]  <= rq_if.cmd_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      cur_data_q <= '0;
      cur_len_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      cur_data_q <= cur_data_d;
      cur_len_q  <= cur_len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Burst sequencing; beat_cnt only increments on non-final beats so it never overflows
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cur_data_d = cur_data_q;
    cur_len_d  = cur_len_q;
    beat_cnt_d = beat_cnt_q;
    pop_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_c) begin
          pop_c      = 1'b1;
          cur_data_d = data_mem[rd_ptr_q];
          cur_len_d  = len_mem[rd_ptr_q];
          beat_cnt_d = '0;
          req_d      = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (last_c) begin
          beat_cnt_d = '0;
`ifdef RR_REQ_BACK_TO_BACK_EN
          if (!empty_c) begin
            pop_c      = 1'b1;
            cur_data_d = data_mem[rd_ptr_q];
            cur_len_d  = len_mem[rd_ptr_q];
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
`else
          req_d   = 1'b0;
          state_d = GAP;
`endif
        end else if (beat_c) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rq_if.cmd_ready  = ~full_c;
  assign rq_if.req        = req_q;
  assign rq_if.bus_valid  = beat_c;
  assign rq_if.bus_data   = cur_data_q + DATA_W'(beat_cnt_q);
  assign rq_if.bus_last   = last_c;
  assign rq_if.busy       = (state_q != IDLE) | ~empty_c;
  assign rq_if.fifo_count = count_q;
endmodule

// File: tb/tb_rr_arb_requester.sv
// Directed bench for rr_arb_requester; expected beats hand-computed from the command stream.
module tb_rr_arb_requester;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  rr_arb_requester_if #(.DATA_W(8), .LEN_W(4), .DEPTH(4)) rq_if ();

  rr_arb_requester #(.DATA_W(8), .LEN_W(4), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .rq_if (rq_if)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] l);
    rq_if.cmd_valid = 1'b1;
    rq_if.cmd_data  = d;
    rq_if.cmd_len   = l;
    step();
    rq_if.cmd_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input logic last);
    #1;
    chk({tag, "_valid"}, 32'(rq_if.bus_valid), 32'(1));
    chk({tag, "_data"},  32'(rq_if.bus_data),  32'(d));
    chk({tag, "_last"},  32'(rq_if.bus_last),  32'(last));
  endtask

  initial begin
    rq_if.cmd_valid = 1'b0;
    rq_if.cmd_data  = '0;
    rq_if.cmd_len   = '0;
    rq_if.gnt       = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_valid", 32'(rq_if.bus_valid), 32'(0));
    end
    chk("rst_req",   32'(rq_if.req),        32'(0));
    chk("rst_ready", 32'(rq_if.cmd_ready),  32'(1));
    chk("rst_busy",  32'(rq_if.busy),       32'(0));
    chk("rst_count", 32'(rq_if.fifo_count), 32'(0));
    chk("rst_last",  32'(rq_if.bus_last),   32'(0));

    // 2: three-beat burst, gnt held high
    rq_if.gnt = 1'b1;
    push(8'h10, 4'd2);
    chk("t2_req_pre", 32'(rq_if.req),        32'(0));
    chk("t2_count",   32'(rq_if.fifo_count), 32'(1));
    step();
    chk("t2_req", 32'(rq_if.req), 32'(1));
    beat("t2_b0", 8'h10, 1'b0); step();
    beat("t2_b1", 8'h11, 1'b0); step();
    beat("t2_b2", 8'h12, 1'b1); step();
    chk("t2_gap_req",   32'(rq_if.req),       32'(0));
    chk("t2_gap_valid", 32'(rq_if.bus_valid), 32'(0));
    chk("t2_gap_busy",  32'(rq_if.busy),      32'(1));
    step();
    chk("t2_idle_busy", 32'(rq_if.busy), 32'(0));

    // 3: wrap FF->00 with gnt 1,0,1
    rq_if.gnt = 1'b0;
    push(8'hFF, 4'd1);
    step();
    chk("t3_req", 32'(rq_if.req), 32'(1));
    rq_if.gnt = 1'b1;
    beat("t3_b0", 8'hFF, 1'b0); step();
    rq_if.gnt = 1'b0; #1;
    chk("t3_hold_valid", 32'(rq_if.bus_valid), 32'(0));
    chk("t3_hold_req",   32'(rq_if.req),       32'(1));
    step();
    rq_if.gnt = 1'b1;
    beat("t3_b1", 8'h00, 1'b1); step();
    rq_if.gnt = 1'b0;
    chk("t3_req_drop", 32'(rq_if.req), 32'(0));
    step(); step();
    chk("t3_busy", 32'(rq_if.busy), 32'(0));

    // 4: overfill FIFO with gnt low, then drain
    for (int i = 0; i < 5; i++) push(8'(8'h20 + i), 4'd0);
    chk("t4_count", 32'(rq_if.fifo_count), 32'(4));
    chk("t4_ready", 32'(rq_if.cmd_ready),  32'(0));
    chk("t4_req",   32'(rq_if.req),        32'(1));
    push(8'h99, 4'd0);
    chk("t4_drop_count", 32'(rq_if.fifo_count), 32'(4));
    rq_if.gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      beat("t4_beat", 8'(8'h20 + i), 1'b1);
      step();
`ifndef RR_REQ_BACK_TO_BACK_EN
      chk("t4_gap_req",   32'(rq_if.req),       32'(0));
      chk("t4_gap_valid", 32'(rq_if.bus_valid), 32'(0));
      step();
      chk("t4_idle_req",  32'(rq_if.req),       32'(0));
      step();
`endif
    end
    chk("t4_end_valid", 32'(rq_if.bus_valid),  32'(0));
    chk("t4_end_req",   32'(rq_if.req),        32'(0));
    chk("t4_end_busy",  32'(rq_if.busy),       32'(0));
    chk("t4_end_count", 32'(rq_if.fifo_count), 32'(0));
    rq_if.gnt = 1'b0;

`ifdef RR_REQ_BACK_TO_BACK_EN
    // 5: back-to-back single-beat bursts keep req high
    push(8'h30, 4'd0);
    push(8'h31, 4'd0);
    rq_if.gnt = 1'b1;
    beat("t5_b0", 8'h30, 1'b1);
    chk("t5_req0", 32'(rq_if.req), 32'(1));
    step();
    beat("t5_b1", 8'h31, 1'b1);
    chk("t5_req1", 32'(rq_if.req), 32'(1));
    step();
    chk("t5_req_drop", 32'(rq_if.req), 32'(0));
    rq_if.gnt = 1'b0;
    step();
`endif

    // max-length burst: 16 beats wrapping through 00, last only on the 16th
    rq_if.gnt = 1'b1;
    push(8'hF8, 4'd15);
    step();
    for (int i = 0; i < 16; i++) begin
      beat("max_beat", 8'(8'hF8 + i), (i == 15));
      step();
    end
    chk("max_req_drop", 32'(rq_if.req), 32'(0));
    step();
    chk("max_busy", 32'(rq_if.busy), 32'(0));
    rq_if.gnt = 1'b0;

    // 6: reset mid-burst flushes FIFO and aborts burst
    push(8'h40, 4'd3);
    push(8'h77, 4'd0);
    chk("t6_count", 32'(rq_if.fifo_count), 32'(1));
    rq_if.gnt = 1'b1;
    beat("t6_b0", 8'h40, 1'b0); step();
    beat("t6_b1", 8'h41, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_req",   32'(rq_if.req),        32'(0));
    chk("t6_count", 32'(rq_if.fifo_count), 32'(0));
    chk("t6_valid", 32'(rq_if.bus_valid),  32'(0));
    chk("t6_last",  32'(rq_if.bus_last),   32'(0));
    chk("t6_busy",  32'(rq_if.busy),       32'(0));
    step();
    chk("t6_idle_valid", 32'(rq_if.bus_valid), 32'(0));
    push(8'h50, 4'd1);
    step();
    beat("t6_n0", 8'h50, 1'b0); step();
    beat("t6_n1", 8'h51, 1'b1); step();
    chk("t6_end_req", 32'(rq_if.req), 32'(0));
    rq_if.gnt = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
